// File: rtl/phase_recover_pkg.sv
// rtl/phase_recover_pkg.sv - shared state type, arctangent table and constants for phase_recover
package phase_recover_pkg;

  typedef enum logic [1:0] {IDLE, ROTATE, SCALE, OUT} state_t;

  localparam int LUT_DEPTH = 64;
  localparam logic [63:0] PI_Q361 = 64'h6487ED5110B4611A;
  localparam logic [31:0] K_INV = 32'd1304065748;

  // atan(2^-i) in Q3.61; entry 0 is pi/4, the rest come from the odd power series.
  function automatic logic [63:0] atan_lut(input int i);
    logic [127:0] acc;
    logic [127:0] term;
    int sh;
    acc = '0;
    if (i == 0) return 64'h1921FB54442D1846;
    if (i >= LUT_DEPTH) return 64'd0;
    for (int k = 0; k < 64; k++) begin
      sh = 124 - i * (2 * k + 1);
      if (sh >= 0) begin
        term = (128'd1 << sh) / 128'(2 * k + 1);
        if (k % 2 == 0) acc = acc + term;
        else acc = acc - term;
      end
    end
    acc = acc >> 63;
    return acc[63:0];
  endfunction

  // Internal angle keeps two fraction bits beyond the phase output: Q3.(pw-1), rounded.
  function automatic logic [63:0] q361_to_z(input logic [63:0] v, input int pw);
    int sh;
    sh = 62 - pw;
    return (v + (64'd1 << (sh - 1))) >> sh;
  endfunction

  function automatic logic [63:0] pi_code(input int pw);
    return PI_Q361 >> (64 - pw);
  endfunction

endpackage

// File: rtl/phase_recover_cordic_vector_stage.sv
// rtl/phase_recover_cordic_vector_stage.sv - one combinational CORDIC vectoring micro-rotation
module cordic_vector_stage
  import phase_recover_pkg::*;
#(
  parameter int XW = 67,
  parameter int ZW = 34,
  parameter int PW = 32,
  parameter int IW = 5
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic [IW-1:0]        i,
  output logic signed [XW-1:0] x_next,
  output logic signed [XW-1:0] y_next,
  output logic signed [ZW-1:0] z_next
);

  logic [ZW-1:0] atan_rom [2**IW];
  logic signed [ZW-1:0] atan;
  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;

  for (genvar g = 0; g < 2**IW; g++) begin : g_rom
    assign atan_rom[g] = ZW'(q361_to_z(atan_lut(g), PW));
  end

  assign atan = atan_rom[i];
  assign xs = x >>> i;
  assign ys = y >>> i;

  always_comb begin
    x_next = x - ys;
    y_next = y + xs;
    z_next = z - atan;
    if (!y[XW-1]) begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/phase_recover.sv
// rtl/phase_recover.sv - iterative CORDIC vectoring: (sin, cos) pair to phase and magnitude
module phase_recover
  import phase_recover_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int PHASE_WIDTH = 32,
  parameter int ITERATIONS  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  sin_in,
  input  logic [DATA_WIDTH-1:0]  cos_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic [DATA_WIDTH-1:0]  magnitude
);

  localparam int XW = DATA_WIDTH + 3;
  localparam int ZW = PHASE_WIDTH + 2;
  localparam int IW = $clog2(ITERATIONS);
  localparam logic [IW-1:0] LAST = IW'(ITERATIONS - 1);
  localparam logic signed [ZW-1:0] Z_HALF_PI = ZW'(q361_to_z(PI_Q361 >> 1, PHASE_WIDTH));
  localparam logic signed [ZW-1:0] Z_RND = ZW'(2);
  localparam logic signed [ZW-1:0] PI_Z = ZW'(pi_code(PHASE_WIDTH));
  localparam logic [PHASE_WIDTH-1:0] PH_MAX = PHASE_WIDTH'(pi_code(PHASE_WIDTH));
  localparam logic [PHASE_WIDTH-1:0] PH_MIN = PHASE_WIDTH'(64'd1 - pi_code(PHASE_WIDTH));

  state_t state;
  logic signed [XW-1:0] x, y, x0, y0, x_n, y_n;
  logic signed [ZW-1:0] z, z0, z_n, z_round;
  logic [IW-1:0] iter;
  logic zero_in;
  logic signed [XW-1:0] sin_x, cos_x;
  logic [XW+31:0] prod;
  logic [DATA_WIDTH-1:0] mag_scaled;
  logic [PHASE_WIDTH-1:0] phase_sat;

  assign sin_x = XW'($signed(sin_in));
  assign cos_x = XW'($signed(cos_in));

  // Fold the left half-plane onto the right so the micro-rotations always converge.
  always_comb begin
    x0 = cos_x;
    y0 = sin_x;
    z0 = '0;
    if (cos_in[DATA_WIDTH-1]) begin
      if (!sin_in[DATA_WIDTH-1]) begin
        x0 = sin_x;
        y0 = -cos_x;
        z0 = Z_HALF_PI;
      end else begin
        x0 = -sin_x;
        y0 = cos_x;
        z0 = -Z_HALF_PI;
      end
    end
  end

  cordic_vector_stage #(.XW(XW), .ZW(ZW), .PW(PHASE_WIDTH), .IW(IW)) u_stage (
    .x(x), .y(y), .z(z), .i(iter),
    .x_next(x_n), .y_next(y_n), .z_next(z_n)
  );

  assign prod = (XW + 32)'($unsigned(x)) * (XW + 32)'(K_INV);
  assign mag_scaled = DATA_WIDTH'(prod >> 31);

  always_comb begin
    z_round = (z + Z_RND) >>> 2;
    phase_sat = PHASE_WIDTH'(z_round);
    if (z_round > PI_Z) phase_sat = PH_MAX;
    else if (z_round <= -PI_Z) phase_sat = PH_MIN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      phase     <= '0;
      magnitude <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      zero_in   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x        <= x0;
            y        <= y0;
            z        <= z0;
            iter     <= '0;
            zero_in  <= (sin_in == '0) && (cos_in == '0);
            in_ready <= 1'b0;
            state    <= ROTATE;
          end
        end
        ROTATE: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (iter == LAST) state <= SCALE;
          else iter <= iter + 1'b1;
        end
        SCALE: begin
          // A zero vector leaves y at zero, so z drifts up the whole table; pin it.
          magnitude <= mag_scaled;
          phase     <= zero_in ? '0 : phase_sat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_recover.sv
// tb/tb_phase_recover.sv - scoreboard bench for phase_recover
module tb_phase_recover;

  localparam int DW = 64;
  localparam int PW = 32;
  localparam int IT = 32;
  localparam real SCALE_IN = 4611686018427387904.0;
  localparam real PH_SCALE = 536870912.0;
  localparam real PI = 3.14159265358979323846;
  localparam real TOL36 = 68719476736.0;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] sin_in, cos_in, magnitude;
  logic [PW-1:0] phase;

  int tests = 0;
  int failed = 0;

  typedef struct {
    real ph;
    real ptol;
    real mg;
    real mtol;
  } exp_t;
  exp_t sb[$];
  real last_ph_rad;

  always #5 clk = ~clk;

  phase_recover #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ITERATIONS(IT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sin_in(sin_in), .cos_in(cos_in), .out_valid(out_valid), .out_ready(out_ready),
    .phase(phase), .magnitude(magnitude)
  );

  function automatic real s2r(input logic [63:0] v);
    longint l;
    real r;
    l = v;
    r = l;
    return r;
  endfunction

  function automatic real u2r(input logic [63:0] v);
    longint h, l;
    real hr, lr;
    h = {32'b0, v[63:32]};
    l = {32'b0, v[31:0]};
    hr = h;
    lr = l;
    return hr * 4294967296.0 + lr;
  endfunction

  task automatic send(input logic [DW-1:0] s, input logic [DW-1:0] c, input real ptol, input real mtol);
    exp_t e;
    real sr, cr;
    int n;
    sr = s2r(s);
    cr = s2r(c);
    e.ph = $atan2(sr, cr) * PH_SCALE;
    e.ptol = ptol;
    e.mg = $sqrt(sr * sr + cr * cr);
    e.mtol = mtol;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!in_ready) begin
      $display("FAIL send_ready: in_ready=%0b required 1 within 200 cycles", in_ready);
      failed++;
    end
    sb.push_back(e);
    sin_in = s;
    cos_in = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic receive(input string name);
    exp_t e;
    int n, p;
    real ph, mg;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!out_valid) begin
      $display("FAIL %s_timeout: out_valid=0 required 1 within 200 cycles", name);
      failed++;
    end else if (sb.size() == 0) begin
      $display("FAIL %s_unexpected: result with empty scoreboard, required none", name);
      failed++;
    end else begin
      e = sb.pop_front();
      p = $signed(phase);
      ph = p;
      mg = u2r(magnitude);
      last_ph_rad = ph / PH_SCALE;
      tests++;
      if (ph - e.ph > e.ptol || e.ph - ph > e.ptol) begin
        $display("FAIL %s_phase: got %0d required %0.1f +/- %0.1f", name, p, e.ph, e.ptol);
        failed++;
      end
      tests++;
      if (mg - e.mg > e.mtol || e.mg - mg > e.mtol) begin
        $display("FAIL %s_magnitude: got %0d required %0.0f +/- %0.0f", name, magnitude, e.mg, e.mtol);
        failed++;
      end
      if (out_ready) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    sin_in = 64'h1000000000000000;
    cos_in = 64'h1000000000000000;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || phase !== '0 || magnitude !== '0) begin
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b phase=%0d magnitude=%0d required 1 0 0 0",
               in_ready, out_valid, phase, magnitude);
      failed++;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_wins: in_ready=%0b required 1 (sample during reset captured)", in_ready);
      failed++;
    end
  endtask

  task automatic test_zero_angle;
    int n;
    send(64'd0, 64'h4000000000000000, 4.0, TOL36);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != IT + 1) begin
      $display("FAIL zero_latency: out_valid after %0d cycles required %0d", n, IT + 1);
      failed++;
    end
    receive("zero");
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL zero_one_cycle: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      failed++;
    end
  endtask

  task automatic test_third_quadrant;
    logic [DW-1:0] v;
    v = -64'sd3260954456333195553;
    send(v, v, 4.0, TOL36);
    receive("third_quadrant");
  endtask

  task automatic test_branch_cut;
    send(64'd0, 64'hC000000000000000, 4.0, TOL36);
    receive("branch_pi");
    tests++;
    if ($signed(phase) <= 0) begin
      $display("FAIL branch_sign: phase=%0d required positive", $signed(phase));
      failed++;
    end
    send(64'd0, 64'd0, 0.0, 0.0);
    receive("zero_vector");
  endtask

  task automatic test_most_negative;
    send(64'h8000000000000000, 64'h8000000000000000, 4.0, 2.0 * TOL36);
    receive("most_negative");
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] p0;
    logic [DW-1:0] m0;
    int n;
    out_ready = 1'b0;
    send(64'h2000000000000000, 64'hC000000000000000, 4.0, TOL36);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    p0 = phase;
    m0 = magnitude;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      sin_in = {$urandom, $urandom};
      cos_in = {$urandom, $urandom};
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || phase !== p0 || magnitude !== m0 || in_ready !== 1'b0) begin
        $display("FAIL backpressure_hold: out_valid=%0b in_ready=%0b phase=%0d magnitude=%0d required 1 0 %0d %0d",
                 out_valid, in_ready, phase, magnitude, p0, m0);
        failed++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    receive("backpressure");
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      failed++;
    end
    n = 0;
    for (int k = 0; k < IT + 10; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    tests++;
    if (n != 0) begin
      $display("FAIL backpressure_ignored: %0d extra out_valid cycles required 0", n);
      failed++;
    end
  endtask

  task automatic test_reset_mid_rotate;
    exp_t dropped;
    int n;
    send(64'h2000000000000000, 64'h3000000000000000, 4.0, TOL36);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dropped = sb.pop_back();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || phase !== '0 || magnitude !== '0) begin
      $display("FAIL mid_reset_values: in_ready=%0b out_valid=%0b phase=%0d magnitude=%0d required 1 0 0 0",
               in_ready, out_valid, phase, magnitude);
      failed++;
    end
    n = 0;
    for (int k = 0; k < IT + 10; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    tests++;
    if (n != 0) begin
      $display("FAIL mid_reset_abort: %0d out_valid cycles for aborted sample (ph %0.1f) required 0", n, dropped.ph);
      failed++;
    end
    send(64'h4000000000000000, 64'd0, 4.0, TOL36);
    receive("half_pi");
  endtask

  task automatic test_back_to_back;
    real t, w, d, sse, rms;
    longint s, c;
    sse = 0.0;
    for (int n = 0; n < 64; n++) begin
      t = n * 16.0 / 256.0;
      s = longint'(SCALE_IN * $sin(t));
      c = longint'(SCALE_IN * $cos(t));
      send(s, c, 16.0, 0.01 * SCALE_IN);
      receive("stream");
      w = t;
      while (w > PI) w = w - 2.0 * PI;
      d = last_ph_rad - w;
      if (d > PI) d = d - 2.0 * PI;
      if (d < -PI) d = d + 2.0 * PI;
      sse = sse + d * d;
    end
    rms = $sqrt(sse / 64.0);
    tests++;
    if (rms >= 9.5367431640625e-7) begin
      $display("FAIL stream_rms: rms error %e rad required below %e", rms, 9.5367431640625e-7);
      failed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sin_in = '0;
    cos_in = '0;
    last_ph_rad = 0.0;
    test_reset();
    test_zero_angle();
    test_third_quadrant();
    test_branch_cut();
    test_most_negative();
    test_backpressure();
    test_reset_mid_rotate();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
      failed++;
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
